// File: rtl/midi_tx_arbiter.sv
// Round-robin arbiter that serialises whole MIDI messages from several sources
// onto one byte-level UART transmitter, with optional running-status compression.
module midi_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter bit RUNNING_STATUS = 1'b1,
  parameter int ACK_TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_status,
  input  logic [8*NUM_REQ-1:0] req_data1,
  input  logic [8*NUM_REQ-1:0] req_data2,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [1:0]           grant_id,
  output logic                 arb_busy,
  output logic                 err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LATCH, START, ACK, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       last_grant;
  logic [1:0]       winner;
  logic [1:0]       rr_idx;
  logic             any_valid;
  logic [7:0]       b_status, b_d1, b_d2;
  logic [1:0]       byte_idx, last_idx;
  logic [CNT_W-1:0] ack_cnt;
  logic [7:0]       last_status;
  logic             rs_valid;

  logic [7:0]       cur_status, cur_d1, cur_d2;
  logic             is_drop, is_chan, is_sys_common, rs_skip;
  logic [1:0]       cls_last;
  logic             ack_expired;

  assign cur_status = req_status[8*grant_id +: 8];
  assign cur_d1     = req_data1[8*grant_id +: 8];
  assign cur_d2     = req_data2[8*grant_id +: 8];

  // Status classification; cls_last is the index of the final byte (0..2).
  always_comb begin
    is_drop       = ~cur_status[7];
    is_chan       = cur_status[7] && (cur_status[7:4] != 4'hF);
    is_sys_common = (cur_status[7:3] == 5'b11110);
    rs_skip       = RUNNING_STATUS && is_chan && rs_valid && (cur_status == last_status);
    if (is_chan && (cur_status[7:5] != 3'b110))
      cls_last = 2'd2;
    else if (is_chan)
      cls_last = 2'd1;
    else
      cls_last = 2'd0;
  end

  // Descending scan so the smallest offset from last_grant wins.
  always_comb begin
    winner    = last_grant;
    any_valid = 1'b0;
    rr_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = 2'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[rr_idx]) begin
        winner    = rr_idx;
        any_valid = 1'b1;
      end
    end
  end

  assign ack_expired = (ack_cnt == CNT_W'(ACK_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    err       = 1'b0;
    req_ready = '0;
    case (state)
      IDLE:  if (any_valid) state_nxt = LATCH;
      LATCH: begin
        req_ready = NUM_REQ'(1) << grant_id;
        if (is_drop) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = START;
        end
      end
      START: if (!tx_busy) begin
        tx_start  = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        if (tx_busy)
          state_nxt = DONE;
        else if (ack_expired) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:  if (!tx_busy) state_nxt = (byte_idx == last_idx) ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  assign arb_busy = (state != IDLE);

  // Message bytes need no reset: they are always captured before use.
  always_ff @(posedge clk) begin
    if (state == LATCH) begin
      b_status <= cur_status;
      b_d1     <= cur_d1;
      b_d2     <= cur_d2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= '0;
      last_grant  <= 2'(NUM_REQ - 1);
      tx_data     <= '0;
      byte_idx    <= '0;
      last_idx    <= '0;
      ack_cnt     <= '0;
      last_status <= '0;
      rs_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          grant_id   <= winner;
          last_grant <= winner;
        end
        LATCH: if (!is_drop) begin
          if (is_sys_common) rs_valid <= 1'b0;
          byte_idx <= rs_skip ? 2'd1 : 2'd0;
          last_idx <= cls_last;
          tx_data  <= rs_skip ? cur_d1 : cur_status;
        end
        START: ack_cnt <= '0;
        ACK: if (!tx_busy) begin
          if (ack_expired)
            rs_valid <= 1'b0;
          else
            ack_cnt <= ack_cnt + 1'b1;
        end
        DONE: if (!tx_busy) begin
          // A channel status byte has just finished on the wire.
          if ((byte_idx == 2'd0) && (b_status[7:4] != 4'hF)) begin
            last_status <= b_status;
            rs_valid    <= 1'b1;
          end
          if (byte_idx != last_idx) begin
            byte_idx <= byte_idx + 1'b1;
            tx_data  <= (byte_idx == 2'd0) ? b_d1 : b_d2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/midi_tx_arbiter.md
# midi_tx_arbiter

Shares the single MIDI UART transmitter (31250 baud, paced by the comms clock) between up to four message sources, such as the sequencer, the note router and the system/realtime generator. It accepts whole MIDI messages over per-requester valid/ready handshakes and arbitrates round-robin. It serialises each message into 1–3 byte-level start/busy transactions on the UART and never interleaves bytes from different messages. It optionally applies MIDI running status to drop repeated status bytes.

## Interface
- NUM_REQ, 4, number of requesters, legal range 2..4.
- RUNNING_STATUS, 1, 1 = omit a status byte equal to the last sent channel status; 0 = always send status.
- ACK_TIMEOUT, 1023, clk cycles to wait for tx_busy to rise after tx_start before aborting the message.

- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester message valid; held high with data stable until that requester's req_ready pulse.
- req_status  in  8*NUM_REQ  status byte, requester i in bits [8i+7:8i].
- req_data1  in  8*NUM_REQ  first data byte, same packing.
- req_data2  in  8*NUM_REQ  second data byte, same packing.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_data  out  8  byte to UART; stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  in  1  UART busy, synchronous to clk; rises at most ACK_TIMEOUT cycles after tx_start and falls when the stop bit completes.
- grant_id  out  2  index of the requester whose message is in progress.
- arb_busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a dropped or aborted message.

## Operation
- States: IDLE, LATCH, START, ACK, DONE.
- IDLE: if any req_valid is set, select the winner round-robin, searching from (last_grant+1) mod NUM_REQ. Register grant_id, set req_ready[winner] for one cycle, and go to LATCH. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- LATCH: capture the winner's three bytes, clear req_ready and classify the status byte:
  - 0x80–0xBF and 0xE0–0xEF: 3 bytes.
  - 0xC0–0xDF: 2 bytes (data2 ignored).
  - 0xF0–0xF7: 1 byte; invalidates running status.
  - 0xF8–0xFF: 1 byte; running status unaffected.
  - below 0x80: drop; pulse err and return to IDLE; running status unaffected.
- Running status skip: applies when RUNNING_STATUS=1, the message is channel class (0x80–0xEF), running status is valid and the status byte equals the last sent status. The status byte is then skipped, so byte count drops by 1. Go to START.
- START: wait for tx_busy=0, then pulse tx_start with tx_data set to the current byte. Go to ACK and clear the timeout counter.
- ACK: on tx_busy=1, go to DONE. If the counter reaches ACK_TIMEOUT, abort: pulse err, invalidate running status, return to IDLE. Remaining bytes are discarded.
- DONE: on tx_busy=0, advance the byte index. If bytes remain, go to START; otherwise go to IDLE.
- A sent channel status byte sets the last status and marks running status valid. This happens in DONE after the status byte completes.
- last_grant updates in IDLE when the grant is issued.
- A req_valid arriving for a non-winner while a message is in progress waits. Arbitration happens only in IDLE.

## Timing
- Reset (asynchronous, any state, including mid-message): state IDLE, tx_start 0, tx_data 0x00, req_ready 0, grant_id 0, arb_busy 0, err 0, running status invalid, last_grant NUM_REQ-1.
- A message in flight at reset is lost; the UART may finish its current byte.
- Latency when the UART is idle: req_valid high at cycle 0 gives req_ready at cycle 1 and tx_start at cycle 2.
- Subsequent bytes: tx_start follows the cycle in which tx_busy is seen low in DONE by 1 cycle (DONE→START→pulse).
- Back-to-back messages: 2 cycles after returning to IDLE. There is no bubble beyond IDLE→LATCH→START.
- Simultaneous valid on all requesters: grants in rotation 0,1,2,3,0…
- tx_start is never asserted while tx_busy=1.
- tx_start is never asserted twice without an intervening tx_busy rise, except across an abort.

## Test plan
- **Single Note On:** req 0 sends 0x90 0x3C 0x64 with the UART model busy 10 cycles per byte. Required: req_ready at cycle 1, then tx bytes 0x90, 0x3C, 0x64 in order, then arb_busy falls.
- **Running status:** req 0 sends the same 0x90 message twice (RUNNING_STATUS=1). Required: second message transmits only 0x3C 0x64. Repeat with RUNNING_STATUS=0; required: 6 bytes total.
- **Round-robin and atomicity:** all 4 requesters valid at once with distinct status bytes. Required: grant order 0,1,2,3; each message's bytes contiguous; 0xC5 0x10 from requester 2 sent as 2 bytes.
- **Classification:** status 0x45 gives an err pulse, no tx_start and a ready pulse. 0xF8 gives 1 byte and a following 0x90 repeat is still skipped. 0xF0 gives 1 byte and a following 0x90 is re-sent.
- **Timeout:** UART model never raises busy after tx_start. Required: err at cycle ACK_TIMEOUT after ACK entry, return to IDLE, and the next identical channel message sends its status byte.
- **Reset mid-message:** assert rst_n low during the second byte's DONE. Required: all outputs at reset values immediately, and a fresh message afterwards sends a full 3 bytes including status.
